infer_bram_tdp: RTL and testbench
=================================

Name: infer_bram_tdp

Overview:
- Parametrised successor to the single-port inferred BRAM: a true dual-port, byte-write-enabled block RAM on one clock.
- Adds per-port read/write, a selectable read latency (1 or 2), a selectable write mode, read-valid strobes, and a hardware clear sweep after reset.
- Used as tightly coupled SoC memory (boot RAM, scratchpad) where one port serves the core and the other serves a debug or DMA master.

Parameters:
ADDR_WIDTH, 10, word address width; depth DEPTH = 2**ADDR_WIDTH words
BYTE_WIDTH, 8, bytes per word; data width = BYTE_WIDTH*8
READ_LATENCY, 1, cycles from accepted access to rddata; legal values 1 or 2; other values are an elaboration error
WRITE_FIRST, 0, 0 = read-first (old data returned on own-port write), 1 = write-first (merged new data returned)
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no sweep, contents retained across reset

Ports:
ram_clk  in  1  single clock, rising edge
ram_rst  in  1  synchronous reset, active-high
init_busy  out  1  clear sweep in progress; both ports ignored while high
a_en  in  1  port A access enable
a_we  in  BYTE_WIDTH  port A byte write enables
a_addr  in  ADDR_WIDTH  port A word address
a_wrdata  in  BYTE_WIDTH*8  port A write data
a_rddata  out  BYTE_WIDTH*8  port A read data
a_rdvalid  out  1  port A read data valid, one-cycle pulse
b_en, b_we, b_addr, b_wrdata, b_rddata, b_rdvalid: port B, same widths and meaning as port A

Behaviour:
- Reset (ram_rst high at a rising edge):
  - a_rddata, b_rddata = 0; a_rdvalid, b_rdvalid = 0; all pipeline valids cleared; sweep counter = 0.
  - init_busy = CLEAR_ON_RESET.
- Clear sweep (CLEAR_ON_RESET=1):
  - Starts at the first edge after ram_rst falls. Each cycle writes ram[cnt] = 0, then cnt++.
  - On the cycle that writes cnt == DEPTH-1, init_busy drops at the next edge. init_busy is therefore high for exactly DEPTH cycles after reset release.
  - ram_rst reasserted mid-sweep restarts the sweep at address 0.
- Access acceptance: a port access is accepted when x_en=1 and init_busy=0. Accesses presented while busy are dropped: no write, no rdvalid.
- Write: for each byte i with x_we[i]=1, ram[x_addr][8i+:8] = x_wrdata[8i+:8] at the accepting edge.
- Read data and latency:
  - Every accepted access, read or write, returns data. x_rdvalid pulses READ_LATENCY cycles after the accepting edge, with x_rddata valid in the same cycle.
  - x_rddata holds its last value when no access completes.
  - Back-to-back accesses give one result per cycle at full throughput.
- Own-port write mode:
  - WRITE_FIRST=0: returns the pre-write word.
  - WRITE_FIRST=1: returns the word with the written bytes merged in.
- Cross-port collisions:
  - Port X reading an address port Y writes in the same cycle always gets the pre-write word, regardless of WRITE_FIRST.
  - Both ports writing the same address in the same cycle: per byte, port A wins where both enable that byte; bytes enabled only by B take B's data.
- READ_LATENCY=2: a second output register follows the array read register. Both stages advance every cycle (no stall input).
- Initial contents are 0 for simulation and FPGA bitstream, independent of the sweep.

Test Plan:
- Reset release with ADDR_WIDTH=4, CLEAR_ON_RESET=1 -> init_busy high exactly 16 cycles. Then an A read of any address -> rddata=0, rdvalid one cycle later (READ_LATENCY=1).
- A writes 0x1122334455667788 to addr 5 with we=0xFF, then reads addr 5 -> rddata=0x1122334455667788. With READ_LATENCY=2, the same data appears 2 cycles after the read.
- Partial write, we=0x0F, wrdata=0xFFFFFFFFFFFFFFFF, to addr 5 holding the value above -> readback 0x11223344FFFFFFFF.
- Same-cycle A write we=0xFF data 0xAA.., B write we=0x81 data 0xBB.. to addr 3 -> readback 0xAAAAAAAAAAAAAAAA. Same cycle B read of addr 3 (no B write) -> B returns the old word.
- WRITE_FIRST=1, A writes 0x55.. with we=0x01 over 0x00.. -> a_rddata=0x0000000000000055 in the same access. WRITE_FIRST=0 -> 0x0.
- ram_rst pulsed at sweep cycle 7 -> init_busy stays high 16 more cycles after release. An a_en read issued while busy -> no a_rdvalid pulse.

Source files
------------

// File: rtl/infer_bram_tdp.sv
// True dual-port, byte-write-enabled block RAM on a single clock.
// It has a selectable read latency (1 or 2), a selectable own-port write
// mode and read-valid strobes. An optional sweep zeroes the whole array
// after reset. Port A has priority over port B when both write the same byte.
module infer_bram_tdp #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    ram_clk,
    input  logic                    ram_rst,
    output logic                    init_busy,
    input  logic                    a_en,
    input  logic [BYTE_WIDTH-1:0]   a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [BYTE_WIDTH*8-1:0] a_wrdata,
    output logic [BYTE_WIDTH*8-1:0] a_rddata,
    output logic                    a_rdvalid,
    input  logic                    b_en,
    input  logic [BYTE_WIDTH-1:0]   b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [BYTE_WIDTH*8-1:0] b_wrdata,
    output logic [BYTE_WIDTH*8-1:0] b_rddata,
    output logic                    b_rdvalid
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int DATA_WIDTH = BYTE_WIDTH * 8;

    // Zero-initialised so both simulation and the FPGA bitstream start cleared.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  a_acc;
    logic                  b_acc;
    logic [DATA_WIDTH-1:0] a_s1_data;
    logic [DATA_WIDTH-1:0] b_s1_data;
    logic                  a_s1_valid;
    logic                  b_s1_valid;

    assign a_acc = a_en & ~init_busy;
    assign b_acc = b_en & ~init_busy;

    // Overlay the enabled bytes of a write onto the stored word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BYTE_WIDTH-1:0] we
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            if (we[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Clear sweep: one word per cycle, busy drops after the last address.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            sweep_cnt <= '0;
            init_busy <= (CLEAR_ON_RESET != 0);
        end else if (init_busy) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (&sweep_cnt) init_busy <= 1'b0;
        end
    end

    // Array writes. Port B is applied before port A, so A wins on shared bytes.
    always_ff @(posedge ram_clk) begin
        if (init_busy && !ram_rst) mem[sweep_cnt] <= '0;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            if (b_acc && b_we[i]) mem[b_addr][8*i +: 8] <= b_wrdata[8*i +: 8];
        end
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            if (a_acc && a_we[i]) mem[a_addr][8*i +: 8] <= a_wrdata[8*i +: 8];
        end
    end

    // First read register. It sees the pre-write array, so a cross-port
    // read always gets the old word. Only the own-port write can be merged in.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            a_s1_valid <= 1'b0;
            b_s1_valid <= 1'b0;
            a_s1_data  <= '0;
            b_s1_data  <= '0;
        end else begin
            a_s1_valid <= a_acc;
            b_s1_valid <= b_acc;
            if (a_acc) a_s1_data <= (WRITE_FIRST != 0) ? merge_bytes(mem[a_addr], a_wrdata, a_we)
                                                      : mem[a_addr];
            if (b_acc) b_s1_data <= (WRITE_FIRST != 0) ? merge_bytes(mem[b_addr], b_wrdata, b_we)
                                                      : mem[b_addr];
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign a_rddata  = a_s1_data;
            assign a_rdvalid = a_s1_valid;
            assign b_rddata  = b_s1_data;
            assign b_rdvalid = b_s1_valid;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] a_s2_data;
            logic [DATA_WIDTH-1:0] b_s2_data;
            logic                  a_s2_valid;
            logic                  b_s2_valid;

            // Output register stage. It advances every cycle and holds its data between results.
            always_ff @(posedge ram_clk) begin
                if (ram_rst) begin
                    a_s2_valid <= 1'b0;
                    b_s2_valid <= 1'b0;
                    a_s2_data  <= '0;
                    b_s2_data  <= '0;
                end else begin
                    a_s2_valid <= a_s1_valid;
                    b_s2_valid <= b_s1_valid;
                    if (a_s1_valid) a_s2_data <= a_s1_data;
                    if (b_s1_valid) b_s2_data <= b_s1_data;
                end
            end

            assign a_rddata  = a_s2_data;
            assign a_rdvalid = a_s2_valid;
            assign b_rddata  = b_s2_data;
            assign b_rdvalid = b_s2_valid;
        end else begin : g_bad_latency
            $error("infer_bram_tdp: READ_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_infer_bram_tdp.sv
// Directed bench for infer_bram_tdp.
// Instance d1 is read-first with latency 1. Instance d2 is write-first with latency 2.
// Both instances share the same stimulus.
module tb_infer_bram_tdp;

    logic        ram_clk;
    logic        ram_rst;
    logic        a_en, b_en;
    logic [7:0]  a_we, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [63:0] a_wrdata, b_wrdata;

    logic        d1_busy, d2_busy;
    logic [63:0] d1_a_rd, d1_b_rd, d2_a_rd, d2_b_rd;
    logic        d1_a_v, d1_b_v, d2_a_v, d2_b_v;

    int checks = 0;
    int errors = 0;
    int n;
    bit saw_valid;

    infer_bram_tdp #(.ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(1),
                     .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) d1 (
        .ram_clk(ram_clk), .ram_rst(ram_rst), .init_busy(d1_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wrdata(a_wrdata),
        .a_rddata(d1_a_rd), .a_rdvalid(d1_a_v),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wrdata(b_wrdata),
        .b_rddata(d1_b_rd), .b_rdvalid(d1_b_v)
    );

    infer_bram_tdp #(.ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(2),
                     .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) d2 (
        .ram_clk(ram_clk), .ram_rst(ram_rst), .init_busy(d2_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wrdata(a_wrdata),
        .a_rddata(d2_a_rd), .a_rdvalid(d2_a_v),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wrdata(b_wrdata),
        .b_rddata(d2_b_rd), .b_rdvalid(d2_b_v)
    );

    // Free-running clock with a 10-time-unit period.
    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    // Advance one edge; drive and sample 1 unit after it.
    task automatic tick();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ae, input logic [7:0] awe, input logic [3:0] aad,
                                  input logic [63:0] awd, input logic be, input logic [7:0] bwe,
                                  input logic [3:0] bad, input logic [63:0] bwd);
        a_en = ae; a_we = awe; a_addr = aad; a_wrdata = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_wrdata = bwd;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 8'h00, 4'h0, 64'h0, 1'b0, 8'h00, 4'h0, 64'h0);
    endtask

    // Directed sequence.
    initial begin
        ram_rst = 1'b1;
        idle();
        tick();
        tick();
        check_output("rst_busy", {63'h0, d1_busy}, 64'h1);
        check_output("rst_a_v", {63'h0, d1_a_v}, 64'h0);
        check_output("rst_b_v_l2", {63'h0, d2_b_v}, 64'h0);
        check_output("rst_a_rd", d1_a_rd, 64'h0);
        check_output("rst_a_rd_l2", d2_a_rd, 64'h0);

        // Release reset and count the cycles in which busy stays high.
        ram_rst = 1'b0;
        n = 0;
        while (d1_busy && n < 40) begin
            n++;
            tick();
        end
        check_output("busy_cycles", 64'(n), 64'd16);

        // Read after the sweep.
        apply_stimulus(1'b1, 8'h00, 4'd9, 64'h0, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("rd9_valid", {63'h0, d1_a_v}, 64'h1);
        check_output("rd9_data", d1_a_rd, 64'h0);
        check_output("rd9_l2_not_yet", {63'h0, d2_a_v}, 64'h0);

        // Full write to address 5, then read it back.
        apply_stimulus(1'b1, 8'hFF, 4'd5, 64'h1122334455667788, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("wr5_readfirst", d1_a_rd, 64'h0);
        apply_stimulus(1'b1, 8'h00, 4'd5, 64'h0, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("rd5_data", d1_a_rd, 64'h1122334455667788);
        idle();
        tick();
        check_output("rd5_idle_novalid", {63'h0, d1_a_v}, 64'h0);
        check_output("rd5_hold", d1_a_rd, 64'h1122334455667788);
        check_output("rd5_l2_valid", {63'h0, d2_a_v}, 64'h1);
        check_output("rd5_l2_data", d2_a_rd, 64'h1122334455667788);

        // Partial write of the low four bytes.
        apply_stimulus(1'b1, 8'h0F, 4'd5, 64'hFFFFFFFFFFFFFFFF, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("pwr5_old", d1_a_rd, 64'h1122334455667788);
        apply_stimulus(1'b1, 8'h00, 4'd5, 64'h0, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("pwr5_readback", d1_a_rd, 64'h11223344FFFFFFFF);

        // Both ports write address 3; A wins every byte it enables.
        apply_stimulus(1'b1, 8'hFF, 4'd3, 64'hAAAAAAAAAAAAAAAA, 1'b1, 8'h81, 4'd3, 64'hBBBBBBBBBBBBBBBB);
        tick();
        apply_stimulus(1'b1, 8'h00, 4'd3, 64'h0, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("coll3_readback", d1_a_rd, 64'hAAAAAAAAAAAAAAAA);

        // Both ports write address 7; B supplies the bytes that only B enables.
        apply_stimulus(1'b1, 8'h0F, 4'd7, 64'hAAAAAAAAAAAAAAAA, 1'b1, 8'h81, 4'd7, 64'hBBBBBBBBBBBBBBBB);
        tick();
        apply_stimulus(1'b0, 8'h00, 4'd0, 64'h0, 1'b1, 8'h00, 4'd7, 64'h0);
        tick();
        check_output("coll7_b_readback", d1_b_rd, 64'hBB000000AAAAAAAA);

        // A writes address 3 while B reads it; B gets the old word.
        apply_stimulus(1'b1, 8'hFF, 4'd3, 64'hCCCCCCCCCCCCCCCC, 1'b1, 8'h00, 4'd3, 64'h0);
        tick();
        check_output("xrd3_b_old", d1_b_rd, 64'hAAAAAAAAAAAAAAAA);
        check_output("xrd3_a_readfirst", d1_a_rd, 64'hAAAAAAAAAAAAAAAA);
        idle();
        tick();
        check_output("xrd3_b_old_l2wf", d2_b_rd, 64'hAAAAAAAAAAAAAAAA);
        check_output("xrd3_a_writefirst_l2", d2_a_rd, 64'hCCCCCCCCCCCCCCCC);

        // Single-byte write to address 2. The old word there is zero.
        apply_stimulus(1'b1, 8'h01, 4'd2, 64'h5555555555555555, 1'b0, 8'h00, 4'h0, 64'h0);
        tick();
        check_output("wf2_readfirst", d1_a_rd, 64'h0);
        idle();
        tick();
        check_output("wf2_writefirst", d2_a_rd, 64'h0000000000000055);
        check_output("wf2_writefirst_v", {63'h0, d2_a_v}, 64'h1);

        // Reset pulse mid-sweep restarts the sweep. A held read is dropped while busy.
        ram_rst = 1'b1;
        tick();
        ram_rst = 1'b0;
        repeat (7) tick();
        ram_rst = 1'b1;
        tick();
        ram_rst = 1'b0;
        apply_stimulus(1'b1, 8'h00, 4'd5, 64'h0, 1'b0, 8'h00, 4'h0, 64'h0);
        n = 0;
        saw_valid = 1'b0;
        while (d1_busy && n < 40) begin
            n++;
            tick();
            if (d1_a_v) saw_valid = 1'b1;
        end
        check_output("rst2_busy_cycles", 64'(n), 64'd16);
        check_output("rst2_no_valid_while_busy", {63'h0, saw_valid}, 64'h0);
        tick();
        check_output("rst2_rd5_valid", {63'h0, d1_a_v}, 64'h1);
        check_output("rst2_rd5_cleared", d1_a_rd, 64'h0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
